// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures execute-stage results and control, resolves
// beq/bne taken, and exposes a forwarding tap. Priority per edge: rst > flush > stall > load.
module ex_mem_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_alu_zero,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_write_reg,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_beq,
  input  logic              ex_bne,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_write_reg,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_mem_to_reg,
  output logic              mem_branch_taken,
  output logic [DATA_W-1:0] mem_branch_target,
  output logic              fwd_en,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;

  // Load values: control qualified by ex_valid; writes to $zero never enable write-back.
  always_comb begin
    valid_d      = ex_valid;
    alu_result_d = ex_alu_result;
    store_data_d = ex_store_data;
    write_reg_d  = ex_write_reg;
    reg_write_d  = ex_valid & ex_reg_write & (ex_write_reg != '0);
    mem_read_d   = ex_valid & ex_mem_read;
    mem_write_d  = ex_valid & ex_mem_write;
    mem_to_reg_d = ex_mem_to_reg;
    target_d     = ex_branch_target;
    taken_d      = ex_valid & ((ex_beq & ex_alu_zero) | (ex_bne & ~ex_alu_zero));
    // beq and bne together is illegal; treat it as unconditionally taken.
    if (ex_beq && ex_bne) begin
      taken_d = ex_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
    end else if (!stall) begin
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
    end
  end

  always_comb begin
    mem_valid         = valid_q;
    mem_alu_result    = alu_result_q;
    mem_store_data    = store_data_q;
    mem_write_reg     = write_reg_q;
    mem_reg_write     = reg_write_q;
    mem_mem_read      = mem_read_q;
    mem_mem_write     = mem_write_q;
    mem_mem_to_reg    = mem_to_reg_q;
    mem_branch_taken  = taken_q;
    mem_branch_target = target_q;
    // Load results come from write-back, so loads never drive this tap.
    fwd_en            = reg_write_q & ~mem_read_q;
    fwd_reg           = write_reg_q;
    fwd_data          = alu_result_q;
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg: one task per scenario, inline checks.
module tb_ex_mem_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic              ex_valid, ex_alu_zero, ex_reg_write, ex_mem_read, ex_mem_write;
  logic              ex_mem_to_reg, ex_beq, ex_bne;
  logic [DATA_W-1:0] ex_alu_result, ex_store_data, ex_branch_target;
  logic [REG_AW-1:0] ex_write_reg;
  logic              mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic              mem_branch_taken, fwd_en;
  logic [DATA_W-1:0] mem_alu_result, mem_store_data, mem_branch_target, fwd_data;
  logic [REG_AW-1:0] mem_write_reg, fwd_reg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .ex_valid         (ex_valid),
    .ex_alu_result    (ex_alu_result),
    .ex_alu_zero      (ex_alu_zero),
    .ex_store_data    (ex_store_data),
    .ex_write_reg     (ex_write_reg),
    .ex_branch_target (ex_branch_target),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .ex_beq           (ex_beq),
    .ex_bne           (ex_bne),
    .mem_valid        (mem_valid),
    .mem_alu_result   (mem_alu_result),
    .mem_store_data   (mem_store_data),
    .mem_write_reg    (mem_write_reg),
    .mem_reg_write    (mem_reg_write),
    .mem_mem_read     (mem_mem_read),
    .mem_mem_write    (mem_mem_write),
    .mem_mem_to_reg   (mem_mem_to_reg),
    .mem_branch_taken (mem_branch_taken),
    .mem_branch_target(mem_branch_target),
    .fwd_en           (fwd_en),
    .fwd_reg          (fwd_reg),
    .fwd_data         (fwd_data)
  );

  // beq and bne together is an illegal decode outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(ex_valid && ex_beq && ex_bne))
        else $error("illegal beq+bne on a valid instruction");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_alu_zero = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0; ex_beq = 1'b0; ex_bne = 1'b0;
    ex_alu_result = '0; ex_store_data = '0; ex_branch_target = '0; ex_write_reg = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    ex_valid = 1'b1; ex_alu_zero = 1'b1; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    ex_mem_write = 1'b1; ex_mem_to_reg = 1'b1; ex_beq = 1'b1; ex_bne = 1'b1;
    ex_alu_result = 32'hDEAD_BEEF; ex_store_data = 32'hCAFE_F00D;
    ex_branch_target = 32'h1234_5678; ex_write_reg = 5'd31;
    tick();
    vectors++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
         mem_branch_taken, fwd_en} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0000000", {mem_valid, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_branch_taken, fwd_en});
    end
    vectors++;
    if (mem_alu_result !== 32'h0 || mem_store_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: result %h store %h expected 0", mem_alu_result, mem_store_data);
    end
    vectors++;
    if (mem_branch_target !== 32'h0 || mem_write_reg !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_target: target %h reg %0d expected 0", mem_branch_target,
               mem_write_reg);
    end
    clear_inputs();
    ex_valid = 1'b1; ex_alu_result = 32'h0000_0010;
    tick();
    vectors++;
    if (mem_alu_result !== 32'h10 || mem_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: result %h valid %b expected 10/1", mem_alu_result, mem_valid);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    ex_valid = 1'b1; ex_beq = 1'b1; ex_alu_zero = 1'b1; ex_branch_target = 32'h0040_0020;
    tick();
    vectors++;
    if (mem_branch_taken !== 1'b1 || mem_branch_target !== 32'h0040_0020) begin
      miscompares++;
      $display("FAIL beq_taken: taken %b target %h expected 1/00400020", mem_branch_taken,
               mem_branch_target);
    end
    ex_alu_zero = 1'b0;
    tick();
    vectors++;
    if (mem_branch_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_not_taken: got %b expected 0", mem_branch_taken);
    end
    ex_beq = 1'b0; ex_bne = 1'b1; ex_alu_zero = 1'b0;
    tick();
    vectors++;
    if (mem_branch_taken !== 1'b1) begin
      miscompares++;
      $display("FAIL bne_taken: got %b expected 1", mem_branch_taken);
    end
    ex_alu_zero = 1'b1;
    tick();
    vectors++;
    if (mem_branch_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL bne_not_taken: got %b expected 0", mem_branch_taken);
    end
    // A taken branch held by stall stays asserted even as inputs change.
    ex_alu_zero = 1'b0;
    tick();
    stall = 1'b1; ex_bne = 1'b0; ex_valid = 1'b0;
    tick();
    vectors++;
    if (mem_branch_taken !== 1'b1) begin
      miscompares++;
      $display("FAIL branch_stall_hold: got %b expected 1", mem_branch_taken);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd8; ex_alu_result = 32'h5;
    tick();
    vectors++;
    if (mem_alu_result !== 32'h5 || mem_write_reg !== 5'd8 || mem_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL add_load: result %h reg %0d we %b expected 5/8/1", mem_alu_result,
               mem_write_reg, mem_reg_write);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_alu_result = 32'h99 + i; ex_write_reg = 5'd3; ex_mem_write = 1'b1;
      ex_reg_write = i[0];
      tick();
      vectors++;
      if (mem_alu_result !== 32'h5 || mem_write_reg !== 5'd8 || mem_reg_write !== 1'b1 ||
          mem_mem_write !== 1'b0 || mem_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: result %h reg %0d we %b mw %b v %b expected 5/8/1/0/1",
                 i, mem_alu_result, mem_write_reg, mem_reg_write, mem_mem_write, mem_valid);
      end
    end
    flush = 1'b1;
    tick();
    vectors++;
    if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0 || mem_alu_result !== 32'h0 ||
        mem_write_reg !== 5'd0) begin
      miscompares++;
      $display("FAIL flush_over_stall: v %b we %b result %h reg %0d expected 0/0/0/0",
               mem_valid, mem_reg_write, mem_alu_result, mem_write_reg);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd0; ex_alu_result = 32'h77;
    tick();
    vectors++;
    if (mem_reg_write !== 1'b0 || fwd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_suppress: we %b fwd_en %b expected 0/0", mem_reg_write, fwd_en);
    end
    ex_write_reg = 5'd9;
    tick();
    vectors++;
    if (mem_reg_write !== 1'b1 || fwd_en !== 1'b1 || fwd_reg !== 5'd9 ||
        fwd_data !== 32'h77) begin
      miscompares++;
      $display("FAIL reg9_fwd: we %b fwd_en %b fwd_reg %0d data %h expected 1/1/9/77",
               mem_reg_write, fwd_en, fwd_reg, fwd_data);
    end
  endtask

  task automatic test_fwd_load();
    clear_inputs();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
    ex_write_reg = 5'd4; ex_alu_result = 32'h1000_0004;
    tick();
    vectors++;
    if (mem_mem_read !== 1'b1 || fwd_en !== 1'b0 || mem_mem_to_reg !== 1'b1 ||
        mem_reg_write !== 1'b1) begin
      miscompares++;
      $display("FAIL load_no_fwd: mr %b fwd_en %b m2r %b we %b expected 1/0/1/1",
               mem_mem_read, fwd_en, mem_mem_to_reg, mem_reg_write);
    end
    ex_mem_read = 1'b0; ex_mem_to_reg = 1'b0; ex_alu_result = 32'hFFFF_FFFF;
    tick();
    vectors++;
    if (fwd_en !== 1'b1 || fwd_data !== 32'hFFFF_FFFF || fwd_reg !== 5'd4) begin
      miscompares++;
      $display("FAIL alu_fwd: fwd_en %b data %h reg %0d expected 1/ffffffff/4", fwd_en,
               fwd_data, fwd_reg);
    end
    // Conflicting read+write pass through unarbitrated.
    ex_mem_read = 1'b1; ex_mem_write = 1'b1; ex_store_data = 32'hA5A5_0001;
    tick();
    vectors++;
    if (mem_mem_read !== 1'b1 || mem_mem_write !== 1'b1 || mem_store_data !== 32'hA5A5_0001) begin
      miscompares++;
      $display("FAIL rw_conflict: mr %b mw %b sd %h expected 1/1/a5a50001", mem_mem_read,
               mem_mem_write, mem_store_data);
    end
  endtask

  task automatic test_invalid();
    clear_inputs();
    ex_valid = 1'b0; ex_mem_write = 1'b1; ex_beq = 1'b1; ex_alu_zero = 1'b1;
    ex_reg_write = 1'b1; ex_write_reg = 5'd7; ex_alu_result = 32'h0000_1234;
    tick();
    vectors++;
    if (mem_mem_write !== 1'b0 || mem_branch_taken !== 1'b0 || mem_valid !== 1'b0 ||
        mem_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL invalid_ctrl: mw %b taken %b v %b we %b expected 0/0/0/0",
               mem_mem_write, mem_branch_taken, mem_valid, mem_reg_write);
    end
    vectors++;
    if (mem_alu_result !== 32'h0000_1234 || mem_write_reg !== 5'd7) begin
      miscompares++;
      $display("FAIL invalid_data: result %h reg %0d expected 1234/7", mem_alu_result,
               mem_write_reg);
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd12; ex_alu_result = 32'hAB;
    tick();
    stall = 1'b1; rst = 1'b1;
    tick();
    vectors++;
    if (mem_valid !== 1'b0 || mem_alu_result !== 32'h0 || mem_reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: v %b result %h we %b expected 0/0/0", mem_valid,
               mem_alu_result, mem_reg_write);
    end
  endtask

  initial begin
    clear_inputs();
    #2;
    test_reset();
    test_branch();
    test_stall_flush();
    test_zero_reg();
    test_fwd_load();
    test_invalid();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
